// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame constants for the UART receiver
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync2.sv
// rtl/uart_rx_sync2.sv - two-flop synchronizer, resets high to match an idle serial line
module uart_rx_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling and one-cycle DV strobe
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 50,
    parameter int CLKS_PER_BIT_W = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 DI,
    output logic                 DV,
    output logic [DATA_BITS-1:0] PO
);

    localparam logic [CLKS_PER_BIT_W-1:0] BIT_LAST  = CLKS_PER_BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [CLKS_PER_BIT_W-1:0] HALF_LAST = CLKS_PER_BIT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_t                state, state_nx;
    logic [CLKS_PER_BIT_W-1:0]  cnt, cnt_nx;
    logic [2:0]                 idx, idx_nx;
    logic [DATA_BITS-1:0]       shift, shift_nx;
    logic [DATA_BITS-1:0]       po_nx;
    logic                       dv_nx;
    logic                       ds, ds_prev;

    uart_rx_sync2 u_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (DI),
        .q     (ds)
    );

    // Edge history follows enabled samples so a sparse CE cannot step over the falling edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ds_prev <= 1'b1;
        end else if (CE) begin
            ds_prev <= ds;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            PO    <= '0;
            DV    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shift <= shift_nx;
            PO    <= po_nx;
            DV    <= dv_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shift_nx = shift;
        po_nx    = PO;
        dv_nx    = 1'b0;
        if (CE) begin
            case (state)
                IDLE: begin
                    cnt_nx = '0;
                    idx_nx = '0;
                    if (!ds && ds_prev) begin
                        state_nx = START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt_nx   = '0;
                        idx_nx   = '0;
                        state_nx = ds ? IDLE : DATA;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt_nx        = '0;
                        shift_nx[idx] = ds;
                        idx_nx        = idx + 1'b1;
                        if (idx == 3'd7) begin
                            state_nx = STOP;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt_nx   = '0;
                        state_nx = IDLE;
                        if (ds) begin
                            po_nx = shift;
                            dv_nx = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed frames
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CE  = 1'b1;
    logic       DI  = 1'b1;
    logic       DV;
    logic [7:0] PO;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    bit         ce_toggle = 1'b0;
    logic       dv_q = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT   (50),
        .CLKS_PER_BIT_W (6)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .CE  (CE),
        .DI  (DI),
        .DV  (DV),
        .PO  (PO)
    );

    always #1 CLK = ~CLK;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        DI = b;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int n);
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(data[i], n);
        send_bit(stop, n);
    endtask

    // Clock-enable generator: steady high, or alternating when ce_toggle is set.
    initial begin
        forever begin
            @(negedge CLK);
            CE = ce_toggle ? ~CE : 1'b1;
        end
    end

    // Monitor: every DV pulse must match the oldest expected byte and last one cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (DV === 1'b1) begin
                check8("dv_width", {7'b0, dv_q}, 8'h00);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dv: got PO=%02h expected no DV", PO);
                end else begin
                    check8("po_byte", PO, exp_q.pop_front());
                end
            end
            dv_q = DV;
        end
    end

    initial begin
        // Reset held with the line toggling
        for (int i = 0; i < 4; i++) begin
            DI = ~DI;
            repeat (3) @(negedge CLK);
            check8("reset_dv", {7'b0, DV}, 8'h00);
            check8("reset_po", PO, 8'h00);
        end
        DI = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        repeat (200) @(negedge CLK);
        check8("idle_po", PO, 8'h00);

        // Good frame
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 50);
        send_bit(1'b1, 20);

        // Missing stop, then line parked low for 4 us
        send_frame(8'h55, 1'b0, 50);
        send_bit(1'b0, 2000);
        check8("framing_po_hold", PO, 8'h55);
        send_bit(1'b1, 100);

        // Start glitch
        send_bit(1'b0, 10);
        send_bit(1'b1, 200);
        check8("glitch_po_hold", PO, 8'h55);

        // Back-to-back frames
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        send_frame(8'hA3, 1'b1, 50);
        send_frame(8'h0F, 1'b1, 50);
        send_bit(1'b1, 100);
        check8("b2b_last_po", PO, 8'h0F);

        // CE every other cycle, doubled bit period
        ce_toggle = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 100);
        send_bit(1'b1, 200);
        ce_toggle = 1'b0;
        send_bit(1'b1, 10);
        check8("ce_po", PO, 8'h5A);

        // Reset mid-byte
        send_bit(1'b0, 50);
        send_bit(1'b1, 50);
        send_bit(1'b0, 50);
        send_bit(1'b1, 50);
        RST = 1'b0;
        DI  = 1'b1;
        repeat (5) @(negedge CLK);
        check8("midreset_dv", {7'b0, DV}, 8'h00);
        check8("midreset_po", PO, 8'h00);
        RST = 1'b1;
        repeat (700) @(negedge CLK);
        check8("post_reset_po", PO, 8'h00);

        // Reception resumes after reset
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, 50);
        send_bit(1'b1, 100);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_dv: got %0d bytes outstanding expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for a fixed 8N1 frame: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit. It oversamples the serial input DI with the system clock, samples each bit at its centre, and presents the received byte on PO with a one-cycle DV strobe. It sits at the serial front end of the synthesizer and feeds the byte-level protocol/MIDI parsing logic.

## Interface
- CLKS_PER_BIT, default 50: enabled clock cycles per bit period; legal range 4 ≤ CLKS_PER_BIT ≤ 2^CLKS_PER_BIT_W.
- CLKS_PER_BIT_W, default 6: width of the bit-timing counter.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset (RST=0 resets; release synchronous to CLK).
- CE   in  1  clock enable; FSM, counters and DV set only advance when CE=1.
- DI   in  1  serial input, idle high.
- DV   out 1  data-valid strobe, high for exactly one CLK cycle per good frame.
- PO   out 8  last correctly received byte, held until the next good frame.

## Operation
- Input path: 2-flop synchronizer on DI (runs every CLK, independent of CE) gives ds; one more flop gives ds_prev for falling-edge detection.
- States:
  - IDLE
  - START
  - DATA
  - STOP
- Encodings live in a shared package.
- IDLE: cnt=0, idx=0. On CE with ds=0 and ds_prev=1 (falling edge) → START. A line held low never re-triggers.
- START: cnt increments each CE cycle. At cnt==CLKS_PER_BIT/2−1 (integer division): if ds=0 → DATA with cnt=0, idx=0; else glitch → IDLE.
- DATA: at cnt==CLKS_PER_BIT−1, sample ds into shift[idx] (LSB first), cnt=0, idx+1. After idx 7 is sampled → STOP.
- STOP: at cnt==CLKS_PER_BIT−1, sample ds:
  - ds=1: PO←shift and DV←1.
  - ds=0 (framing error): PO unchanged, no DV.
  - Either way → IDLE.
- Counter arithmetic is CLKS_PER_BIT_W bits, unsigned, compared with equality only; idx is 3 bits.
- CE=0: FSM, cnt, idx and shift hold; a frame resumes when CE returns.

## Timing
- Reset values: DV=0, PO=8'h00, state=IDLE, cnt=0, idx=0, shift=0, sync flops=1 (so no false edge is detected after reset).
- Reset asserted mid-frame aborts immediately. After release, reception restarts only on a new falling edge.
- Latency, with CE=1 throughout: DV rises (2 sync + 1 edge) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after DI falls, ±1 cycle.
- DV clears on the next CLK edge regardless of CE.
- PO changes in the same cycle DV rises and is stable from then on.
- Back-to-back frames: a start edge arriving in the cycle after STOP completes is accepted. The next start bit may begin immediately after the stop-bit centre.
- Framing error followed by a low line: no new frame until DI returns high and falls again.

## Structure
- Package uart_pkg:
  - state enum/localparams (IDLE, START, DATA, STOP);
  - DATA_BITS=8.
- Single module with no submodule, except an optional sync2 two-flop synchronizer cell, which is natural to factor out and reuse.
- Target size: 120–250 lines of RTL.

## Test plan
- Reset: RST=0 with DI toggling → DV=0, PO=00 throughout; release, no DV without a start edge.
- Good frame: CLKS_PER_BIT=50, CLK period 2 ns, CE=1, DI bit period 100 ns. Send start, data 1,0,1,0,1,0,1,0 (LSB first), stop high → exactly one DV pulse of one CLK cycle, PO=8'h55.
- Missing stop: same frame but stop bit held low → no DV, PO stays 8'h55. Line then held low for 4 µs → no further DV.
- Glitch: DI low for 10 cycles then high → returns to IDLE, no DV.
- Back-to-back frames: 8'hA3 then 8'h0F with no idle gap → two DV pulses, PO=A3 then 0F.
- CE gating: CE=1 every other cycle with bit period doubled → byte 8'h5A received correctly. Async reset asserted mid-byte → DV never asserted for that frame.
